// File: rtl/mux_scan_pkg.sv
// Shared definitions for the scanning multiplexer: mode encodings, FSM states
// and the select-width helper.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    // Bits needed to index n items, never less than 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_sel.sv
// Combinational CHANNELS:1 selector; returns zero and a cleared in_range flag
// when sel points past the last channel.
module mux_sel #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [WIDTH-1:0]          y,
    output logic                      in_range
);

    always_comb begin
        y = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k)) y = d[k*WIDTH +: WIDTH];
        end
    end

    assign in_range = ({1'b0, sel} < (SEL_W + 1)'(CHANNELS));

endmodule

// File: rtl/mux_scan.sv
// N-channel registered multiplexer with manual select and a dwell-timed scan
// through all channels; every sample is tagged with its source channel.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_MANUAL | output follows external select a; idx/cnt parked at 0
// ST_SCAN   | output follows internal idx, advanced every dwell+1 samples
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic                      en,
    input  logic [SEL_W-1:0]          a,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [DWELL_W-1:0]        dwell,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          ch,
    output logic                      valid,
    output logic                      wrap
);

    if (CHANNELS < 2 || SEL_W != clog2(CHANNELS)) begin : g_bad_param
        $error("mux_scan: SEL_W must equal clog2(CHANNELS) and CHANNELS >= 2");
    end

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

    state_t             st, st_nxt;
    logic [SEL_W-1:0]   idx, idx_nxt, scan_idx, sel;
    logic [DWELL_W-1:0] cnt, cnt_nxt, scan_cnt;
    logic [WIDTH-1:0]   sel_y, y_nxt;
    logic [SEL_W-1:0]   ch_nxt;
    logic               sel_ok, dwell_done, at_last, valid_nxt, wrap_nxt;

    mux_sel #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_sel (
        .sel      (sel),
        .d        (d),
        .y        (sel_y),
        .in_range (sel_ok)
    );

    always_comb begin
        st_nxt    = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
        // Entering scan from manual always starts at channel 0, count 0.
        scan_idx  = (st == ST_SCAN) ? idx : '0;
        scan_cnt  = (st == ST_SCAN) ? cnt : '0;
        sel       = (mode == MODE_SCAN) ? scan_idx : a;
        dwell_done = (scan_cnt >= dwell);
        at_last   = (scan_idx == LAST_IDX);

        idx_nxt   = idx;
        cnt_nxt   = cnt;
        y_nxt     = y;
        ch_nxt    = ch;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;

        if (mode == MODE_MANUAL) begin
            idx_nxt = '0;
            cnt_nxt = '0;
        end else if (en) begin
            if (dwell_done) begin
                cnt_nxt = '0;
                idx_nxt = at_last ? '0 : scan_idx + SEL_W'(1);
            end else begin
                cnt_nxt = scan_cnt + DWELL_W'(1);
                idx_nxt = scan_idx;
            end
        end

        if (en) begin
            y_nxt  = sel_y;
            ch_nxt = sel;
            if (mode == MODE_SCAN) begin
                valid_nxt = 1'b1;
                wrap_nxt  = dwell_done && at_last;
            end else begin
                valid_nxt = sel_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= ST_MANUAL;
            idx   <= '0;
            cnt   <= '0;
            y     <= '0;
            ch    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            st    <= st_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            y     <= y_nxt;
            ch    <= ch_nxt;
            valid <= valid_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule
